// File: rtl/s_fifo_pkg.sv
// Shared defaults for the single-clock FIFO.
package s_fifo_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned CDEPTH_DEF = 3;
  localparam int unsigned DEPTH_DEF  = 1 << CDEPTH_DEF;

endpackage

// File: rtl/s_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for s_fifo; decides which requests are accepted.
module s_fifo_ctrl
  import s_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CDEPTH = CDEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wreq,
  input  logic              i_rreq,
  output logic              wr_ok,
  output logic              rd_ok,
  output logic [CDEPTH-1:0] wp,
  output logic [CDEPTH-1:0] rp,
  output logic              empty,
  output logic              full
);

  localparam logic [CDEPTH:0] FULL_CNT = (CDEPTH + 1)'(DEPTH);

  logic [CDEPTH:0] cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

  // A read frees a slot in the same cycle, so a write into a full FIFO is
  // still accepted when paired with a read.
  assign rd_ok = i_rreq & ~empty;
  assign wr_ok = i_wreq & (~full | rd_ok);

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/s_fifo.sv
// Synchronous single-clock FIFO with registered read data and full/empty flags.
// Storage lives in this module as `mem` so it can be probed hierarchically.
module s_fifo
  import s_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CDEPTH = CDEPTH_DEF
) (
  output logic [WIDTH-1:0] Data_out,
  output logic             fifoisempty,
  output logic             fifoisfull,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             i_rreq,
  input  logic             i_wreq,
  input  logic             clk,
  input  logic             reset_n
);

  logic              wr_ok;
  logic              rd_ok;
  logic [CDEPTH-1:0] wp;
  logic [CDEPTH-1:0] rp;
  logic [WIDTH-1:0]  mem [DEPTH];

  s_fifo_ctrl #(
    .DEPTH  (DEPTH),
    .CDEPTH (CDEPTH)
  ) u_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .i_wreq  (i_wreq),
    .i_rreq  (i_rreq),
    .wr_ok   (wr_ok),
    .rd_ok   (rd_ok),
    .wp      (wp),
    .rp      (rp),
    .empty   (fifoisempty),
    .full    (fifoisfull)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wp] <= Data_in;
    end
  end

  // No write-to-read bypass: a read only ever returns a word already stored.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      Data_out <= '0;
    end else if (rd_ok) begin
      Data_out <= mem[rp];
    end
  end

endmodule

// File: tb/tb_s_fifo.sv
// Directed self-checking bench for s_fifo.
module tb_s_fifo;

  logic [7:0] Data_out;
  logic       fifoisempty;
  logic       fifoisfull;
  logic [7:0] Data_in;
  logic       i_rreq;
  logic       i_wreq;
  logic       clk;
  logic       reset_n;

  int checks = 0;
  int errors = 0;

  s_fifo dut (
    .Data_out    (Data_out),
    .fifoisempty (fifoisempty),
    .fifoisfull  (fifoisfull),
    .Data_in     (Data_in),
    .i_rreq      (i_rreq),
    .i_wreq      (i_wreq),
    .clk         (clk),
    .reset_n     (reset_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    i_wreq  = 1'b0;
    i_rreq  = 1'b0;
    Data_in = 8'h00;

    // reset held for 4 cycles, requests ignored
    i_wreq = 1'b1;
    i_rreq = 1'b1;
    Data_in = 8'hee;
    repeat (4) tick();
    check("rst_empty", 32'(fifoisempty), 32'd1);
    check("rst_full", 32'(fifoisfull), 32'd0);
    check("rst_dout", 32'(Data_out), 32'd0);
    for (int k = 0; k < 8; k++) check($sformatf("rst_mem%0d", k), 32'(dut.mem[k]), 32'd0);
    i_wreq = 1'b0;
    i_rreq = 1'b0;
    reset_n = 1'b0;
    tick();
    check("idle_empty", 32'(fifoisempty), 32'd1);

    // fill with 3..10
    for (int i = 0; i < 8; i++) begin
      Data_in = 8'(3 + i);
      i_wreq  = 1'b1;
      tick();
      check($sformatf("fill_empty%0d", i), 32'(fifoisempty), 32'd0);
      check($sformatf("fill_full%0d", i), 32'(fifoisfull), (i == 7) ? 32'd1 : 32'd0);
    end
    i_wreq = 1'b0;
    for (int k = 0; k < 8; k++) check($sformatf("fill_mem%0d", k), 32'(dut.mem[k]), 32'(3 + k));

    // overflow write is dropped
    Data_in = 8'd11;
    i_wreq  = 1'b1;
    tick();
    i_wreq = 1'b0;
    check("ovf_mem0", 32'(dut.mem[0]), 32'd3);
    check("ovf_full", 32'(fifoisfull), 32'd1);
    check("ovf_empty", 32'(fifoisempty), 32'd0);
    check("ovf_cnt", 32'(dut.u_ctrl.cnt), 32'd8);

    // drain
    for (int i = 0; i < 8; i++) begin
      i_rreq = 1'b1;
      tick();
      check($sformatf("drain_dout%0d", i), 32'(Data_out), 32'(3 + i));
      check($sformatf("drain_empty%0d", i), 32'(fifoisempty), (i == 7) ? 32'd1 : 32'd0);
      check($sformatf("drain_full%0d", i), 32'(fifoisfull), 32'd0);
    end
    tick();
    i_rreq = 1'b0;
    check("underflow_dout", 32'(Data_out), 32'd10);
    check("underflow_empty", 32'(fifoisempty), 32'd1);

    // refill 20..24 at indices 0..4
    for (int i = 0; i < 5; i++) begin
      Data_in = 8'(20 + i);
      i_wreq  = 1'b1;
      tick();
    end
    i_wreq = 1'b0;
    check("refill_cnt", 32'(dut.u_ctrl.cnt), 32'd5);

    // simultaneous read/write for 4 cycles; writes 25..28 land at 5,6,7,0
    for (int i = 0; i < 4; i++) begin
      Data_in = 8'(25 + i);
      i_wreq  = 1'b1;
      i_rreq  = 1'b1;
      tick();
      check($sformatf("rw_dout%0d", i), 32'(Data_out), 32'(20 + i));
      check($sformatf("rw_cnt%0d", i), 32'(dut.u_ctrl.cnt), 32'd5);
    end
    i_wreq = 1'b0;
    i_rreq = 1'b0;
    check("rw_mem5", 32'(dut.mem[5]), 32'd25);
    check("rw_mem6", 32'(dut.mem[6]), 32'd26);
    check("rw_mem7", 32'(dut.mem[7]), 32'd27);
    check("rw_mem0", 32'(dut.mem[0]), 32'd28);
    check("rw_mem4", 32'(dut.mem[4]), 32'd24);

    // asynchronous reset mid-operation
    reset_n = 1'b1;
    #1;
    check("arst_empty", 32'(fifoisempty), 32'd1);
    check("arst_full", 32'(fifoisfull), 32'd0);
    check("arst_dout", 32'(Data_out), 32'd0);
    check("arst_mem5", 32'(dut.mem[5]), 32'd0);
    tick();
    reset_n = 1'b0;
    i_rreq = 1'b1;
    tick();
    i_rreq = 1'b0;
    check("post_rst_read_dout", 32'(Data_out), 32'd0);
    check("post_rst_read_empty", 32'(fifoisempty), 32'd1);

    // read+write while empty: write only, no bypass
    Data_in = 8'h55;
    i_wreq  = 1'b1;
    i_rreq  = 1'b1;
    tick();
    i_wreq = 1'b0;
    i_rreq = 1'b0;
    check("empty_rw_dout", 32'(Data_out), 32'd0);
    check("empty_rw_empty", 32'(fifoisempty), 32'd0);
    check("empty_rw_cnt", 32'(dut.u_ctrl.cnt), 32'd1);
    check("empty_rw_mem0", 32'(dut.mem[0]), 32'h55);
    i_rreq = 1'b1;
    tick();
    i_rreq = 1'b0;
    check("empty_rw_read", 32'(Data_out), 32'h55);
    check("empty_rw_final", 32'(fifoisempty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
